keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
Scan sequencer for the 4x4 matrix keypad feeding the Morse encoder. Drives the rows one at a time, active-low, and samples the columns once per row dwell. Debounces press and release, rejects multi-column ghosts, and delivers one key event per press over a valid/ready handshake. The key-code format is the codebase's existing 8-bit {row one-hot, col one-hot} encoding.

Parameters:
SCAN_DIV, 1000, clk cycles per row dwell; must be >= 4; column sample taken on the last cycle of the dwell
DEBOUNCE_SCANS, 4, consecutive matching samples needed to confirm a press or a release; must be >= 1
REPEAT_DELAY, 50, dwell periods of continuous hold before the first auto-repeat (optional feature only)
REPEAT_RATE, 10, dwell periods between auto-repeats (optional feature only)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
col  in  4  keypad columns, active-low, asynchronous to clk
row  out  4  keypad row drive, one-hot-low
key_code  out  8  {~row[0],~row[1],~row[2],~row[3],~col[0],~col[1],~col[2],~col[3]} of the confirmed key
key_idx  out  4  row_sel*4 + col_index, where col_index is the position of the active-low bit in col
key_valid  out  1  event available
key_ready  in  1  consumer accepts the event
key_down  out  1  debounced level: high while a confirmed key is held
overrun  out  1  sticky: an event was dropped
clr_overrun  in  1  clears overrun

Behaviour:
- Reset (async assert, sync deassert internally):
  - row=4'b1110, row_sel=0, key_code=0, key_idx=0, key_valid=0, key_down=0, overrun=0.
  - Dwell counter=0, state=SCAN, all debounce/repeat counters 0.
- col passes through a 2-flop synchroniser; only the synchronised value is used.
- Dwell counter:
  - Counts 0..SCAN_DIV-1 and wraps; the terminal count (TC) is the sample point.
  - When row_sel changes, row updates on the clock after TC.
- Hit classification at TC:
  - Hit: exactly one bit of ~col_sync is set.
  - Zero bits set, or two or more bits set (ghost): no hit.
- SCAN:
  - Hit at TC -> latch candidate (row_sel, col), deb_cnt=1, go to DEBOUNCE; row is not advanced.
  - No hit -> advance row_sel (3 wraps to 0).
- DEBOUNCE (row held):
  - Same hit at TC -> deb_cnt++.
  - When deb_cnt reaches DEBOUNCE_SCANS -> emit event, key_down=1, go to HOLD.
  - Different column or no hit -> go to SCAN and advance row_sel.
  - DEBOUNCE_SCANS=1 goes SCAN -> HOLD directly on the first hit.
- HOLD (row held):
  - At TC: candidate column bit high -> rel_cnt++; otherwise rel_cnt=0.
  - When rel_cnt reaches DEBOUNCE_SCANS -> key_down=0, go to SCAN, advance row_sel.
  - Other columns are ignored while in HOLD.
- Emit (handshake):
  - Loads key_code/key_idx and sets key_valid=1 on the next edge if key_valid=0, or if key_valid=1 and key_ready=1 in the same cycle.
  - key_valid=1 and key_ready=0 -> new event dropped, overrun=1.
  - key_valid=1 and key_ready=1 with no new event -> key_valid=0 next cycle.
  - key_code/key_idx are stable while key_valid=1.
- overrun: clr_overrun clears it; a simultaneous set wins.
- Async reset mid-scan or mid-HOLD: all outputs take reset values immediately, with no event emitted. After reset, scanning restarts at row 0.

Optional Feature:
KEYPAD_REPEAT_EN.
- Defined:
  - In HOLD, a hold counter increments at each TC where the candidate is still pressed.
  - At REPEAT_DELAY, emit a repeat event with the identical code, then one every REPEAT_RATE TCs.
  - Repeats obey the same emit/overrun rules.
  - Any release sample resets the hold counter.
- Undefined: exactly one event per press; the REPEAT_* parameters are unused and no repeat logic is synthesised.

Test Plan:
1. SCAN_DIV=8, DEBOUNCE_SCANS=3. Pulse rst_n low, then release with col=4'hF -> row=1110 during reset, then 1110, 1101, 1011, 0111 every 8 clk, wrapping; key_valid stays 0.
2. Hold col=4'b1101 whenever row=1011, key_ready=1 -> key_valid pulses once with key_code=8'h24 and key_idx=9; key_down=1; row stays 1011 until release. After 3 released samples: key_down=0 and scanning resumes at row 0111.
3. Bounce: col=1101 for 2 samples on row 1011, then 4'hF -> no key_valid; row advances to 0111 after the failed sample.
4. Ghost: col=4'b1100 on any row -> no DEBOUNCE entry, no event, row keeps rotating.
5. key_ready=0; press row0 col0 (8'h88, idx 0), release, then press row3 col3 -> key_code stays 8'h88 and overrun=1. Pulse key_ready -> key_valid=0. Pulse clr_overrun -> overrun=0.
6. rst_n asserted while in HOLD with key_valid=1 -> key_valid, key_down and overrun go to 0 and row=1110 with no clock edge needed. Deassert with the key still held -> press is re-debounced and one new event is emitted.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_ctrl
//  Brief    : 4x4 matrix keypad scanner with debounce, ghost rejection and a
//             valid/ready key-event output. Optional auto-repeat is built
//             when KEYPAD_REPEAT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [7:0] key_code,
  output logic [3:0] key_idx,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overrun,
  input  logic       clr_overrun
);

  localparam int C_DIV_W = $clog2(SCAN_DIV);
  localparam int C_DEB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(SCAN_DIV - 1);
  localparam logic [C_DEB_W-1:0] C_DEB_LAST = C_DEB_W'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic [3:0]         r_col_meta;
  logic [3:0]         r_col_sync;
  logic [C_DIV_W-1:0] r_dwell;
  state_t             r_state;
  logic [1:0]         r_row_sel;
  logic [3:0]         r_row;
  logic [3:0]         r_cand_col;
  logic [C_DEB_W-1:0] r_deb_cnt;
  logic [C_DEB_W-1:0] r_rel_cnt;
  logic               r_key_down;
  logic [7:0]         r_key_code;
  logic [3:0]         r_key_idx;
  logic               r_key_valid;
  logic               r_overrun;

  logic               w_tc;
  logic [3:0]         w_act;
  logic               w_hit;
  logic               w_released;
  logic [1:0]         w_next_sel;
  logic               w_confirm;
  logic               w_rep;
  logic               w_emit;
  logic [3:0]         w_ev_col;
  logic [3:0]         w_row_oh;
  logic [1:0]         w_col_idx;
  logic [7:0]         w_ev_code;
  logic [3:0]         w_ev_idx;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
      r_dwell    <= '0;
    end else begin
      r_col_meta <= col;
      r_col_sync <= r_col_meta;
      r_dwell    <= w_tc ? '0 : r_dwell + C_DIV_W'(1);
    end
  end

  assign w_tc       = (r_dwell == C_DIV_LAST);
  assign w_act      = ~r_col_sync;
  assign w_hit      = (w_act != 4'd0) && ((w_act & (w_act - 4'd1)) == 4'd0);
  assign w_released = (r_col_sync & r_cand_col) != 4'd0;
  assign w_next_sel = r_row_sel + 2'd1;

  assign w_confirm = w_tc && w_hit &&
                     (((r_state == ST_SCAN) && (DEBOUNCE_SCANS == 1)) ||
                      ((r_state == ST_DEBOUNCE) && (w_act == r_cand_col) &&
                       (r_deb_cnt == C_DEB_LAST)));
  assign w_emit    = w_confirm | w_rep;

  // A first press takes its column from the live sample; a repeat uses the latch.
  assign w_ev_col  = (r_state == ST_HOLD) ? r_cand_col : w_act;
  assign w_row_oh  = 4'b0001 << r_row_sel;

  always_comb begin
    w_col_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_ev_col[i]) w_col_idx = 2'(i);
    end
  end

  assign w_ev_code = {w_row_oh[0], w_row_oh[1], w_row_oh[2], w_row_oh[3],
                      w_ev_col[0], w_ev_col[1], w_ev_col[2], w_ev_col[3]};
  assign w_ev_idx  = {r_row_sel, w_col_idx};

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= ST_SCAN;
      r_row_sel  <= 2'd0;
      r_row      <= 4'b1110;
      r_cand_col <= 4'd0;
      r_deb_cnt  <= '0;
      r_rel_cnt  <= '0;
      r_key_down <= 1'b0;
    end else if (w_tc) begin
      case (r_state)
        ST_SCAN: begin
          if (w_hit) begin
            r_cand_col <= w_act;
            r_deb_cnt  <= C_DEB_W'(1);
            r_rel_cnt  <= '0;
            if (DEBOUNCE_SCANS == 1) begin
              r_state    <= ST_HOLD;
              r_key_down <= 1'b1;
            end else begin
              r_state <= ST_DEBOUNCE;
            end
          end else begin
            r_row_sel <= w_next_sel;
            r_row     <= ~(4'b0001 << w_next_sel);
          end
        end
        ST_DEBOUNCE: begin
          if (w_hit && (w_act == r_cand_col)) begin
            if (r_deb_cnt == C_DEB_LAST) begin
              r_state    <= ST_HOLD;
              r_key_down <= 1'b1;
              r_rel_cnt  <= '0;
            end else begin
              r_deb_cnt <= r_deb_cnt + C_DEB_W'(1);
            end
          end else begin
            r_state   <= ST_SCAN;
            r_row_sel <= w_next_sel;
            r_row     <= ~(4'b0001 << w_next_sel);
          end
        end
        ST_HOLD: begin
          if (w_released) begin
            if (r_rel_cnt == C_DEB_LAST) begin
              r_state    <= ST_SCAN;
              r_key_down <= 1'b0;
              r_rel_cnt  <= '0;
              r_row_sel  <= w_next_sel;
              r_row      <= ~(4'b0001 << w_next_sel);
            end else begin
              r_rel_cnt <= r_rel_cnt + C_DEB_W'(1);
            end
          end else begin
            r_rel_cnt <= '0;
          end
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int C_HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int C_HOLD_W   = $clog2(C_HOLD_MAX + 1);
  localparam logic [C_HOLD_W-1:0] C_DELAY_LAST = C_HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [C_HOLD_W-1:0] C_RATE_LAST  = C_HOLD_W'(REPEAT_RATE - 1);

  logic [C_HOLD_W-1:0] r_hold_cnt;
  logic                r_rep_phase;

  assign w_rep = w_tc && (r_state == ST_HOLD) && !w_released &&
                 (r_hold_cnt == (r_rep_phase ? C_RATE_LAST : C_DELAY_LAST));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hold_cnt  <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_tc) begin
      if ((r_state == ST_HOLD) && !w_released) begin
        if (w_rep) begin
          r_hold_cnt  <= '0;
          r_rep_phase <= 1'b1;
        end else begin
          r_hold_cnt <= r_hold_cnt + C_HOLD_W'(1);
        end
      end else begin
        r_hold_cnt  <= '0;
        r_rep_phase <= 1'b0;
      end
    end
  end
`else
  // Constant-false; keeps the repeat parameters referenced in this build.
  assign w_rep = (REPEAT_DELAY < 0) && (REPEAT_RATE < 0);
`endif

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_key_code  <= 8'd0;
      r_key_idx   <= 4'd0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_emit && (!r_key_valid || key_ready)) begin
        r_key_code  <= w_ev_code;
        r_key_idx   <= w_ev_idx;
        r_key_valid <= 1'b1;
      end else if (r_key_valid && key_ready) begin
        r_key_valid <= 1'b0;
      end
      if (w_emit && r_key_valid && !key_ready) r_overrun <= 1'b1;
      else if (clr_overrun)                    r_overrun <= 1'b0;
    end
  end

  assign row       = r_row;
  assign key_code  = r_key_code;
  assign key_idx   = r_key_idx;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scan_ctrl
//  Brief    : Self-checking bench for keypad_scan_ctrl (SCAN_DIV=8, 3 scans).
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col;
  logic [3:0] row;
  logic [7:0] key_code;
  logic [3:0] key_idx;
  logic       key_valid;
  logic       key_ready = 1'b1;
  logic       key_down;
  logic       overrun;
  logic       clr_overrun = 1'b0;

  logic       k_en = 1'b0;
  logic       k_ghost = 1'b0;
  logic [1:0] k_row = 2'd0;
  logic [3:0] k_col = 4'hF;
  logic [3:0] k_row_n;

  typedef struct packed {
    logic [7:0] code;
    logic [3:0] idx;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         ev_count = 0;
  logic [3:0] rot_seq [4] = '{4'b1011, 4'b0111, 4'b1110, 4'b1101};

  keypad_scan_ctrl #(
    .SCAN_DIV       (8),
    .DEBOUNCE_SCANS (3),
    .REPEAT_DELAY   (50),
    .REPEAT_RATE    (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .col         (col),
    .row         (row),
    .key_code    (key_code),
    .key_idx     (key_idx),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_down    (key_down),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  // Keypad matrix: the pressed key pulls its column low only while its row is driven.
  assign k_row_n = ~(4'b0001 << k_row);
  assign col = k_ghost ? 4'b1100 : ((k_en && (row == k_row_n)) ? k_col : 4'hF);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] c, input logic [3:0] i);
    ev_t e;
    e.code = c;
    e.idx  = i;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && key_valid && key_ready) begin
      ev_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got code %0h idx %0d expected none", key_code, key_idx);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_code", key_code, e.code);
        check("event_idx", key_idx, e.idx);
      end
    end
  end

  task automatic wait_row(input logic [3:0] target);
    int n = 0;
    while (row === target && n < 200) begin @(negedge clk); n++; end
    while (row !== target && n < 200) begin @(negedge clk); n++; end
    check("wait_row", row, target);
  endtask

  task automatic wait_down(input logic lvl);
    int n = 0;
    while (key_down !== lvl && n < 400) begin @(negedge clk); n++; end
    check("wait_key_down", key_down, lvl);
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1 key_ready = 1'b1;
    @(posedge clk); #1 key_ready = 1'b0;
  endtask

  initial begin
    int ev0;

    // Reset values and free-running row rotation
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_row", row, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_down", key_down, 0);
    check("rst_overrun", overrun, 0);
    check("rst_code", key_code, 0);
    check("rst_idx", key_idx, 0);
    rst_n = 1'b1;
    wait_row(4'b1101);
    for (int i = 0; i < 4; i++) begin
      repeat (8) @(negedge clk);
      check("row_rotate", row, rot_seq[i]);
    end
    check("rotate_no_valid", key_valid, 0);

    // Clean press on row 2 / col 1
    ev0 = ev_count;
    k_row = 2'd2; k_col = 4'b1101; k_en = 1'b1;
    push_exp(8'h24, 4'd9);
    wait_down(1'b1);
    check("hold_row", row, 4'b1011);
    repeat (40) @(negedge clk);
    check("hold_row_stays", row, 4'b1011);
    check("single_event", ev_count - ev0, 1);
    k_en = 1'b0;
    wait_down(1'b0);
    check("resume_row", row, 4'b0111);

    // Bounce: two matching samples, then released
    ev0 = ev_count;
    wait_row(4'b1011);
    k_en = 1'b1;
    repeat (16) @(negedge clk);
    check("bounce_row_held", row, 4'b1011);
    k_en = 1'b0;
    repeat (8) @(negedge clk);
    check("bounce_row_advance", row, 4'b0111);
    check("bounce_no_down", key_down, 0);
    check("bounce_no_event", ev_count - ev0, 0);

    // Ghost: two columns low on every row
    ev0 = ev_count;
    k_ghost = 1'b1;
    wait_row(4'b1110);
    for (int i = 0; i < 3; i++) begin
      repeat (8) @(negedge clk);
      check("ghost_rotate", row, rot_seq[(i + 3) % 4]);
    end
    check("ghost_no_down", key_down, 0);
    check("ghost_no_event", ev_count - ev0, 0);
    k_ghost = 1'b0;

    // Overrun: consumer stalled across two presses
    key_ready = 1'b0;
    k_row = 2'd0; k_col = 4'b1110; k_en = 1'b1;
    push_exp(8'h88, 4'd0);
    wait_down(1'b1);
    check("ovr_valid", key_valid, 1);
    check("ovr_code_first", key_code, 8'h88);
    check("ovr_idx_first", key_idx, 0);
    check("ovr_not_yet", overrun, 0);
    k_en = 1'b0;
    wait_down(1'b0);
    k_row = 2'd3; k_col = 4'b0111; k_en = 1'b1;
    wait_down(1'b1);
    check("ovr_code_kept", key_code, 8'h88);
    check("ovr_set", overrun, 1);
    k_en = 1'b0;
    wait_down(1'b0);
    pulse_ready();
    @(negedge clk);
    check("ready_clears_valid", key_valid, 0);
    check("overrun_sticky", overrun, 1);
    @(posedge clk); #1 clr_overrun = 1'b1;
    @(posedge clk); #1 clr_overrun = 1'b0;
    @(negedge clk);
    check("clr_overrun", overrun, 0);

    // Async reset while holding with a pending event and overrun set
    ev0 = ev_count;
    k_row = 2'd2; k_col = 4'b1110; k_en = 1'b1;
    wait_down(1'b1);
    k_en = 1'b0;
    wait_down(1'b0);
    k_row = 2'd1; k_col = 4'b1011; k_en = 1'b1;
    wait_down(1'b1);
    check("pre_rst_valid", key_valid, 1);
    check("pre_rst_overrun", overrun, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_valid", key_valid, 0);
    check("async_down", key_down, 0);
    check("async_overrun", overrun, 0);
    check("async_row", row, 4'b1110);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1 key_ready = 1'b1;
    push_exp(8'h42, 4'd6);
    wait_down(1'b1);
    repeat (4) @(negedge clk);
    check("post_rst_event", ev_count - ev0, 1);
    k_en = 1'b0;
    wait_down(1'b0);
    repeat (16) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("total_events", ev_count, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
